param_sync_fifo: RTL and testbench

PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

---
 rtl/param_sync_fifo.sv | 117 +++++++++++
 tb/tb_param_sync_fifo.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/param_sync_fifo.sv
// Single-clock parameterised FIFO with registered or first-word-fall-through read,
// occupancy counter, almost-full/empty thresholds and overflow/underflow pulses.
module param_sync_fifo #(
    parameter int unsigned Width           = 8,
    parameter int unsigned Depth           = 16,
    parameter int unsigned Almost_full_th  = 12,
    parameter int unsigned Almost_empty_th = 2,
    parameter bit          Fwft            = 1'b0
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic                     Wr_en,
    input  logic [Width-1:0]         Data_in,
    input  logic                     Rd_en,
    output logic [Width-1:0]         Data_out,
    output logic                     Data_valid,
    output logic                     Wr_Full,
    output logic                     Rd_Empty,
    output logic                     Almost_full,
    output logic                     Almost_empty,
    output logic [$clog2(Depth):0]   Count,
    output logic                     Overflow,
    output logic                     Underflow
);

    localparam int unsigned AW    = $clog2(Depth);
    localparam logic [AW:0] FULL_C = (AW+1)'(Depth);
    localparam logic [AW:0] AF_TH  = (AW+1)'(Almost_full_th);
    localparam logic [AW:0] AE_TH  = (AW+1)'(Almost_empty_th);

    logic [Width-1:0] mem_q [Depth];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             ovf_q, unf_q;
    logic             wr_acc, rd_acc;
    logic [Width-1:0] head;

    // All status flags come from the registered count so they move together.
    assign Wr_Full      = (count_q == FULL_C);
    assign Rd_Empty     = (count_q == '0);
    assign Almost_full  = (count_q >= AF_TH);
    assign Almost_empty = (count_q <= AE_TH);
    assign Count        = count_q;
    assign Overflow     = ovf_q;
    assign Underflow    = unf_q;

    assign head = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_acc   = Wr_en && !Wr_Full;
        rd_acc   = Rd_en && !Rd_Empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= Wr_en && Wr_Full;
            unf_q    <= Rd_en && Rd_Empty;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge Clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q[AW-1:0]] <= Data_in;
        end
    end

    generate
        if (Fwft) begin : g_fwft
            assign Data_out   = Rd_Empty ? '0 : head;
            assign Data_valid = !Rd_Empty;
        end else begin : g_reg
            logic [Width-1:0] dout_q;
            logic             dvalid_q;

            always_ff @(posedge Clk or negedge Reset_n) begin
                if (!Reset_n) begin
                    dout_q   <= '0;
                    dvalid_q <= 1'b0;
                end else begin
                    dvalid_q <= rd_acc;
                    if (rd_acc) begin
                        dout_q <= head;
                    end
                end
            end

            assign Data_out   = dout_q;
            assign Data_valid = dvalid_q;
        end
    endgenerate

endmodule

// File: tb/tb_param_sync_fifo.sv
// Bench for param_sync_fifo: one registered-read and one FWFT instance, each checked
// against a queue-based reference model under directed and random traffic.
module tb_param_sync_fifo;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned AF    = 12;
    localparam int unsigned AE    = 2;

    logic       Clk;
    logic       rst0_n, wr0, rd0;
    logic [7:0] din0, dout0;
    logic       dv0, full0, empty0, af0, ae0, ovf0, unf0;
    logic [4:0] cnt0;
    logic       rst1_n, wr1, rd1;
    logic [7:0] din1, dout1;
    logic       dv1, full1, empty1, af1, ae1, ovf1, unf1;
    logic [4:0] cnt1;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] mq[$];
    logic [7:0] fq[$];
    logic [7:0] e_dout0;
    logic       e_dv0, e_ovf0, e_unf0;
    logic       e_ovf1, e_unf1;

    param_sync_fifo #(.Width(8), .Depth(DEPTH), .Almost_full_th(AF),
                      .Almost_empty_th(AE), .Fwft(1'b0)) dut0 (
        .Clk(Clk), .Reset_n(rst0_n), .Wr_en(wr0), .Data_in(din0), .Rd_en(rd0),
        .Data_out(dout0), .Data_valid(dv0), .Wr_Full(full0), .Rd_Empty(empty0),
        .Almost_full(af0), .Almost_empty(ae0), .Count(cnt0),
        .Overflow(ovf0), .Underflow(unf0));

    param_sync_fifo #(.Width(8), .Depth(DEPTH), .Almost_full_th(AF),
                      .Almost_empty_th(AE), .Fwft(1'b1)) dut1 (
        .Clk(Clk), .Reset_n(rst1_n), .Wr_en(wr1), .Data_in(din1), .Rd_en(rd1),
        .Data_out(dout1), .Data_valid(dv1), .Wr_Full(full1), .Rd_Empty(empty1),
        .Almost_full(af1), .Almost_empty(ae1), .Count(cnt1),
        .Overflow(ovf1), .Underflow(unf1));

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // One cycle of traffic on the registered-read FIFO, called at a falling edge.
    task automatic cyc0(input logic w, input logic [7:0] d, input logic r);
        int sz;
        sz = mq.size();
        wr0 = w; din0 = d; rd0 = r;
        e_ovf0 = w && (sz == DEPTH);
        e_unf0 = r && (sz == 0);
        e_dv0  = r && (sz > 0);
        if (e_dv0) e_dout0 = mq.pop_front();
        if (w && sz < DEPTH) mq.push_back(d);
        @(posedge Clk);
        @(negedge Clk);
        wr0 = 1'b0; rd0 = 1'b0;
    endtask

    task automatic cyc1(input logic w, input logic [7:0] d, input logic r);
        int sz;
        sz = fq.size();
        wr1 = w; din1 = d; rd1 = r;
        e_ovf1 = w && (sz == DEPTH);
        e_unf1 = r && (sz == 0);
        if (r && sz > 0) void'(fq.pop_front());
        if (w && sz < DEPTH) fq.push_back(d);
        @(posedge Clk);
        @(negedge Clk);
        wr1 = 1'b0; rd1 = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge Clk);
        n_cmp++; if (cnt0 !== 5'd0)   begin n_err++; $display("FAIL rst_count0: got %0d want 0", cnt0); end
        n_cmp++; if (empty0 !== 1'b1) begin n_err++; $display("FAIL rst_empty0: got %b want 1", empty0); end
        n_cmp++; if (full0 !== 1'b0)  begin n_err++; $display("FAIL rst_full0: got %b want 0", full0); end
        n_cmp++; if (ae0 !== 1'b1)    begin n_err++; $display("FAIL rst_ae0: got %b want 1", ae0); end
        n_cmp++; if (af0 !== 1'b0)    begin n_err++; $display("FAIL rst_af0: got %b want 0", af0); end
        n_cmp++; if (dout0 !== 8'h00) begin n_err++; $display("FAIL rst_dout0: got %h want 00", dout0); end
        n_cmp++; if (dv0 !== 1'b0)    begin n_err++; $display("FAIL rst_dv0: got %b want 0", dv0); end
        n_cmp++; if (ovf0 !== 1'b0 || unf0 !== 1'b0) begin n_err++; $display("FAIL rst_pulses0: got %b%b want 00", ovf0, unf0); end
        n_cmp++; if (cnt1 !== 5'd0 || empty1 !== 1'b1 || dv1 !== 1'b0 || dout1 !== 8'h00)
            begin n_err++; $display("FAIL rst_fwft: got cnt=%0d empty=%b dv=%b dout=%h want 0 1 0 00", cnt1, empty1, dv1, dout1); end
        rst0_n = 1'b1; rst1_n = 1'b1;
        cyc0(1'b0, 8'h00, 1'b0);
        n_cmp++; if (cnt0 !== 5'd0) begin n_err++; $display("FAIL rst_idle_count: got %0d want 0", cnt0); end
    endtask

    task automatic test_underflow();
        cyc0(1'b0, 8'h00, 1'b1);
        n_cmp++; if (unf0 !== 1'b1) begin n_err++; $display("FAIL unf_pulse: got %b want 1", unf0); end
        n_cmp++; if (dv0 !== 1'b0)  begin n_err++; $display("FAIL unf_dv: got %b want 0", dv0); end
        n_cmp++; if (cnt0 !== 5'd0) begin n_err++; $display("FAIL unf_count: got %0d want 0", cnt0); end
        cyc0(1'b0, 8'h00, 1'b0);
        n_cmp++; if (unf0 !== 1'b0) begin n_err++; $display("FAIL unf_clear: got %b want 0", unf0); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) begin
            cyc0(1'b1, 8'(i), 1'b0);
            n_cmp++; if (cnt0 !== 5'(i + 1)) begin n_err++; $display("FAIL fill_count: got %0d want %0d", cnt0, i + 1); end
            n_cmp++; if (af0 !== (i + 1 >= 12)) begin n_err++; $display("FAIL fill_af: got %b want %b at %0d", af0, (i + 1 >= 12), i + 1); end
            n_cmp++; if (full0 !== (i == 15)) begin n_err++; $display("FAIL fill_full: got %b want %b", full0, (i == 15)); end
            n_cmp++; if (empty0 !== 1'b0) begin n_err++; $display("FAIL fill_empty: got %b want 0", empty0); end
            n_cmp++; if (ae0 !== (i + 1 <= 2)) begin n_err++; $display("FAIL fill_ae: got %b want %b", ae0, (i + 1 <= 2)); end
        end
    endtask

    task automatic test_overflow();
        cyc0(1'b1, 8'hAA, 1'b0);
        n_cmp++; if (ovf0 !== 1'b1) begin n_err++; $display("FAIL ovf_pulse: got %b want 1", ovf0); end
        n_cmp++; if (cnt0 !== 5'd16) begin n_err++; $display("FAIL ovf_count: got %0d want 16", cnt0); end
        cyc0(1'b0, 8'h00, 1'b0);
        n_cmp++; if (ovf0 !== 1'b0) begin n_err++; $display("FAIL ovf_clear: got %b want 0", ovf0); end
        // Write while full alongside an accepted read: read goes through, write does not.
        cyc0(1'b1, 8'hBB, 1'b1);
        n_cmp++; if (ovf0 !== 1'b1)  begin n_err++; $display("FAIL ovf_wr_rd_pulse: got %b want 1", ovf0); end
        n_cmp++; if (cnt0 !== 5'd15) begin n_err++; $display("FAIL ovf_wr_rd_count: got %0d want 15", cnt0); end
        n_cmp++; if (dout0 !== 8'h00 || dv0 !== 1'b1) begin n_err++; $display("FAIL ovf_wr_rd_data: got %h/%b want 00/1", dout0, dv0); end
        for (int i = 1; i < 16; i++) begin
            cyc0(1'b0, 8'h00, 1'b1);
            n_cmp++; if (dout0 !== 8'(i) || dv0 !== 1'b1) begin n_err++; $display("FAIL ovf_drain: got %h/%b want %h/1", dout0, dv0, 8'(i)); end
        end
        n_cmp++; if (empty0 !== 1'b1 || cnt0 !== 5'd0) begin n_err++; $display("FAIL ovf_drained: got empty=%b cnt=%0d want 1 0", empty0, cnt0); end
        cyc0(1'b0, 8'h00, 1'b0);
        n_cmp++; if (dv0 !== 1'b0 || dout0 !== 8'h0F) begin n_err++; $display("FAIL hold_after_read: got %b/%h want 0/0f", dv0, dout0); end
    endtask

    task automatic test_wrap();
        int wn, rn, budget;
        logic w, r;
        wn = 1; rn = 1; budget = 0;
        while (rn <= 40 && budget < 2000) begin
            budget++;
            w = (wn <= 40) && ($urandom_range(0, 1) == 1);
            r = ($urandom_range(0, 1) == 1);
            if (w && mq.size() < DEPTH) begin
                cyc0(1'b1, 8'(wn), r);
                wn++;
            end else begin
                cyc0(w, 8'(wn), r);
            end
            if (dv0) begin
                n_cmp++; if (dout0 !== 8'(rn)) begin n_err++; $display("FAIL wrap_order: got %0d want %0d", dout0, rn); end
                rn++;
            end
            n_cmp++; if (cnt0 > 5'd16 || cnt0 !== 5'(mq.size())) begin n_err++; $display("FAIL wrap_count: got %0d want %0d", cnt0, mq.size()); end
        end
        n_cmp++; if (rn != 41) begin n_err++; $display("FAIL wrap_timeout: got %0d reads want 40", rn - 1); end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 5; i++) cyc0(1'b1, 8'($urandom), 1'b0);
        for (int i = 0; i < 10; i++) begin
            cyc0(1'b1, 8'($urandom), 1'b1);
            n_cmp++; if (cnt0 !== 5'd5) begin n_err++; $display("FAIL simul_count: got %0d want 5", cnt0); end
            n_cmp++; if (af0 !== 1'b0 || ae0 !== 1'b0) begin n_err++; $display("FAIL simul_flags: got af=%b ae=%b want 0 0", af0, ae0); end
            n_cmp++; if (dout0 !== e_dout0 || dv0 !== 1'b1) begin n_err++; $display("FAIL simul_data: got %h want %h", dout0, e_dout0); end
        end
        for (int i = 0; i < 4; i++) cyc0(1'b0, 8'h00, 1'b1);
        cyc0(1'b1, 8'h77, 1'b1);
        n_cmp++; if (dout0 !== e_dout0 || cnt0 !== 5'd1) begin n_err++; $display("FAIL occ1_simul: got %h cnt=%0d want %h cnt=1", dout0, cnt0, e_dout0); end
        cyc0(1'b0, 8'h00, 1'b1);
        n_cmp++; if (dout0 !== 8'h77 || cnt0 !== 5'd0) begin n_err++; $display("FAIL occ1_next: got %h cnt=%0d want 77 cnt=0", dout0, cnt0); end
    endtask

    task automatic test_random_reg();
        int pw;
        for (int i = 0; i < 400; i++) begin
            pw = (i < 200) ? 70 : 30;
            cyc0($urandom_range(0, 99) < pw, 8'($urandom), $urandom_range(0, 99) >= pw);
            n_cmp++;
            if (cnt0 !== 5'(mq.size()) || full0 !== (mq.size() == DEPTH) || empty0 !== (mq.size() == 0)
                || af0 !== (mq.size() >= AF) || ae0 !== (mq.size() <= AE)) begin
                n_err++; $display("FAIL rnd_status: got cnt=%0d f=%b e=%b af=%b ae=%b want cnt=%0d", cnt0, full0, empty0, af0, ae0, mq.size());
            end
            n_cmp++; if (dv0 !== e_dv0 || dout0 !== e_dout0) begin n_err++; $display("FAIL rnd_data: got %h/%b want %h/%b", dout0, dv0, e_dout0, e_dv0); end
            n_cmp++; if (ovf0 !== e_ovf0 || unf0 !== e_unf0) begin n_err++; $display("FAIL rnd_pulses: got %b%b want %b%b", ovf0, unf0, e_ovf0, e_unf0); end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) cyc0(1'b1, 8'($urandom), 1'b0);
        #2 rst0_n = 1'b0;
        #1;
        n_cmp++; if (cnt0 !== 5'd0 || empty0 !== 1'b1 || ae0 !== 1'b1 || dv0 !== 1'b0 || dout0 !== 8'h00)
            begin n_err++; $display("FAIL mid_reset: got cnt=%0d e=%b ae=%b dv=%b dout=%h want 0 1 1 0 00", cnt0, empty0, ae0, dv0, dout0); end
        mq.delete(); e_dout0 = 8'h00; e_dv0 = 1'b0;
        @(negedge Clk);
        rst0_n = 1'b1;
        cyc0(1'b1, 8'h3C, 1'b0);
        n_cmp++; if (cnt0 !== 5'd1) begin n_err++; $display("FAIL release_write: got %0d want 1", cnt0); end
        cyc0(1'b1, 8'h3D, 1'b0);
        cyc0(1'b0, 8'h00, 1'b1);
        n_cmp++; if (dout0 !== 8'h3C) begin n_err++; $display("FAIL release_first_read: got %h want 3c", dout0); end
    endtask

    task automatic test_fwft();
        int budget;
        cyc1(1'b1, 8'h5C, 1'b0);
        n_cmp++; if (dout1 !== 8'h5C || dv1 !== 1'b1 || empty1 !== 1'b0) begin n_err++; $display("FAIL fwft_first: got %h/%b want 5c/1", dout1, dv1); end
        cyc1(1'b0, 8'h00, 1'b1);
        n_cmp++; if (empty1 !== 1'b1 || dv1 !== 1'b0) begin n_err++; $display("FAIL fwft_ack: got e=%b dv=%b want 1 0", empty1, dv1); end
        for (int i = 0; i < 300; i++) begin
            cyc1($urandom_range(0, 99) < ((i < 150) ? 70 : 30), 8'($urandom), $urandom_range(0, 99) >= ((i < 150) ? 70 : 30));
            n_cmp++; if (cnt1 !== 5'(fq.size()) || full1 !== (fq.size() == DEPTH) || af1 !== (fq.size() >= AF) || ae1 !== (fq.size() <= AE))
                begin n_err++; $display("FAIL fwft_status: got cnt=%0d want %0d", cnt1, fq.size()); end
            n_cmp++; if (dv1 !== (fq.size() > 0)) begin n_err++; $display("FAIL fwft_valid: got %b want %b", dv1, (fq.size() > 0)); end
            if (fq.size() > 0) begin
                n_cmp++; if (dout1 !== fq[0]) begin n_err++; $display("FAIL fwft_head: got %h want %h", dout1, fq[0]); end
            end
            n_cmp++; if (ovf1 !== e_ovf1 || unf1 !== e_unf1) begin n_err++; $display("FAIL fwft_pulses: got %b%b want %b%b", ovf1, unf1, e_ovf1, e_unf1); end
        end
        budget = 0;
        while (fq.size() != 7 && budget < 100) begin
            budget++;
            cyc1(fq.size() < 7, 8'($urandom), fq.size() > 7);
        end
        n_cmp++; if (cnt1 !== 5'd7) begin n_err++; $display("FAIL fwft_reach7: got %0d want 7", cnt1); end
        #2 rst1_n = 1'b0;
        #1;
        n_cmp++; if (cnt1 !== 5'd0 || empty1 !== 1'b1 || dv1 !== 1'b0) begin n_err++; $display("FAIL fwft_reset: got cnt=%0d e=%b dv=%b want 0 1 0", cnt1, empty1, dv1); end
        fq.delete();
        @(negedge Clk);
        rst1_n = 1'b1;
        cyc1(1'b0, 8'h00, 1'b0);
        n_cmp++; if (cnt1 !== 5'd0 || dv1 !== 1'b0) begin n_err++; $display("FAIL fwft_post_reset: got cnt=%0d dv=%b want 0 0", cnt1, dv1); end
    endtask

    initial begin
        rst0_n = 1'b0; rst1_n = 1'b0;
        wr0 = 1'b0; rd0 = 1'b0; din0 = 8'h00;
        wr1 = 1'b0; rd1 = 1'b0; din1 = 8'h00;
        e_dout0 = 8'h00; e_dv0 = 1'b0; e_ovf0 = 1'b0; e_unf0 = 1'b0;
        e_ovf1 = 1'b0; e_unf1 = 1'b0;
        test_reset();
        test_underflow();
        test_fill();
        test_overflow();
        test_wrap();
        test_simultaneous();
        test_random_reg();
        test_reset_mid();
        test_fwft();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
